fc_layer_param: RTL and testbench

- Parametrised fully-connected layer: computes y = sat(W·x) for an N-element signed input vector and an M-row weight matrix, using P parallel MAC lanes.
- Successor to the fixed-dimension layerK_* blocks; dimensions, width and parallelism are set by parameters.
- Adds a runtime weight-load port (replaces the hard-wired ROM) and saturating output.
- Chains stage-to-stage in the multi-layer top through the same valid/ready stream ports.

---
 rtl/fc_layer_param.sv | 178 +++++++++++++++++
 tb/tb_fc_layer_param.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_param.sv
// fc_layer_param: parametrised fully-connected layer, y = sat(W * x).
// An N-element signed vector streams in, P rows are reduced at a time on P
// parallel MAC lanes, and the M results stream out in row order.
// Weights live in a runtime-writable RAM that is only writable while the
// block waits for a new input vector.
// Build option: define FC_RELU_EN to clamp negative outputs to zero after
// saturation. The port list is the same in both builds.
module fc_layer_param #(
    parameter int M     = 8,
    parameter int N     = 8,
    parameter int P     = 2,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(M*N)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] s_data_in_x,
    input  logic                    s_valid_x,
    output logic                    s_ready_x,
    input  logic signed [WIDTH-1:0] w_data_in,
    input  logic [AW-1:0]           w_addr,
    input  logic                    w_wr_en,
    output logic signed [WIDTH-1:0] m_data_out_y,
    output logic                    m_valid_y,
    input  logic                    m_ready_y
);

    localparam int PW    = 2*WIDTH;
    localparam int ACC_W = 2*WIDTH + $clog2(N);
    localparam int XW    = (N > 1) ? $clog2(N) : 1;
    localparam int CW    = $clog2(N+2);
    localparam int OW    = (P > 1) ? $clog2(P) : 1;
    localparam int RW    = $clog2(M+1);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        $signed({{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {LOAD_X, COMPUTE, OUTPUT} state_t;

    state_t                  state;
    logic [XW-1:0]           xcnt;
    logic [CW-1:0]           ccnt;
    logic [OW-1:0]           ocnt;
    logic [RW-1:0]           row_base;
    logic [XW-1:0]           rd_col;

    logic signed [WIDTH-1:0] w_mem [M*N];
    logic signed [WIDTH-1:0] x_mem [N];
    logic signed [WIDTH-1:0] w_rd  [P];
    logic signed [PW-1:0]    prod  [P];
    logic signed [ACC_W-1:0] acc   [P];
    logic                    prod_vld;

    // Clamp an accumulator to the output range, then optionally apply ReLU.
    function automatic logic signed [WIDTH-1:0] sat(input logic signed [ACC_W-1:0] a);
        logic signed [WIDTH-1:0] r;
        if (a > SAT_MAX)
            r = SAT_MAX[WIDTH-1:0];
        else if (a < SAT_MIN)
            r = SAT_MIN[WIDTH-1:0];
        else
            r = a[WIDTH-1:0];
`ifdef FC_RELU_EN
        if (r[WIDTH-1])
            r = '0;
`endif
        return r;
    endfunction

    assign rd_col = ccnt[XW-1:0];

    // Weight RAM write port, open only while waiting for an input vector.
    // NOTE: storage arrays get no reset; a reset branch would stop them mapping onto RAM.
    always_ff @(posedge clk) begin
        if (state == LOAD_X && w_wr_en && (int'(w_addr) < M*N))
            w_mem[w_addr] <= w_data_in;
    end

    // Input vector buffer, filled one element per accepted handshake.
    always_ff @(posedge clk) begin
        if (state == LOAD_X && s_valid_x && s_ready_x)
            x_mem[xcnt] <= s_data_in_x;
    end

    // Per-lane weight fetch for the current column of rows row_base..row_base+P-1.
    // NOTE: every element is assigned on every pass, so no latch is inferred.
    always_comb begin
        for (int p = 0; p < P; p++) begin
            w_rd[p] = w_mem[AW'((int'(row_base) + p) * N + int'(rd_col))];
        end
    end

    // MAC pipeline: multiply stage, then accumulate stage, cleared at compute start.
    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_vld <= 1'b0;
            for (int p = 0; p < P; p++) begin
                prod[p] <= '0;
                acc[p]  <= '0;
            end
        end else begin
            prod_vld <= (state == COMPUTE) && (ccnt < CW'(N));
            for (int p = 0; p < P; p++) begin
                prod[p] <= PW'(x_mem[rd_col]) * PW'(w_rd[p]);
                if (state == COMPUTE && ccnt == '0)
                    acc[p] <= '0;
                else if (prod_vld)
                    acc[p] <= acc[p] + ACC_W'(prod[p]);
            end
        end
    end

    // Control FSM with registered stream handshakes and output data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= LOAD_X;
            xcnt         <= '0;
            ccnt         <= '0;
            ocnt         <= '0;
            row_base     <= '0;
            s_ready_x    <= 1'b0;
            m_valid_y    <= 1'b0;
            m_data_out_y <= '0;
        end else begin
            case (state)
                LOAD_X: begin
                    s_ready_x <= 1'b1;
                    if (s_valid_x && s_ready_x) begin
                        if (xcnt == XW'(N-1)) begin
                            xcnt      <= '0;
                            ccnt      <= '0;
                            row_base  <= '0;
                            s_ready_x <= 1'b0;
                            state     <= COMPUTE;
                        end else begin
                            xcnt <= xcnt + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (ccnt == CW'(N+1)) begin
                        ccnt         <= '0;
                        ocnt         <= '0;
                        m_valid_y    <= 1'b1;
                        m_data_out_y <= sat(acc[0]);
                        state        <= OUTPUT;
                    end else begin
                        ccnt <= ccnt + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (m_ready_y) begin
                        if (ocnt == OW'(P-1)) begin
                            ocnt      <= '0;
                            m_valid_y <= 1'b0;
                            if (row_base + RW'(P) == RW'(M)) begin
                                row_base  <= '0;
                                s_ready_x <= 1'b1;
                                state     <= LOAD_X;
                            end else begin
                                row_base <= row_base + RW'(P);
                                state    <= COMPUTE;
                            end
                        end else begin
                            ocnt         <= ocnt + 1'b1;
                            m_data_out_y <= sat(acc[ocnt + 1'b1]);
                        end
                    end
                end
                default: state <= LOAD_X;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_param.sv
// Directed testbench for fc_layer_param (M=N=8, P=2, WIDTH=16).
// Expected outputs are hand-computed constants; ReLU-dependent expectations
// follow FC_RELU_EN.
module tb_fc_layer_param;

    localparam int M = 8;
    localparam int N = 8;
    localparam int P = 2;
    localparam int WIDTH = 16;
    localparam int AW = 6;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic signed [WIDTH-1:0] s_data_in_x = '0;
    logic                    s_valid_x = 1'b0;
    logic                    s_ready_x;
    logic signed [WIDTH-1:0] w_data_in = '0;
    logic [AW-1:0]           w_addr = '0;
    logic                    w_wr_en = 1'b0;
    logic signed [WIDTH-1:0] m_data_out_y;
    logic                    m_valid_y;
    logic                    m_ready_y = 1'b0;

    int checks = 0;
    int failures = 0;

    logic signed [WIDTH-1:0] wm [M*N];
    logic signed [WIDTH-1:0] xv [N];
    longint                  ev [M];

    fc_layer_param #(.M(M), .N(N), .P(P), .WIDTH(WIDTH), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_x  (s_data_in_x),
        .s_valid_x    (s_valid_x),
        .s_ready_x    (s_ready_x),
        .w_data_in    (w_data_in),
        .w_addr       (w_addr),
        .w_wr_en      (w_wr_en),
        .m_data_out_y (m_data_out_y),
        .m_valid_y    (m_valid_y),
        .m_ready_y    (m_ready_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_w();
        for (int i = 0; i < M*N; i++) begin
            w_addr    = AW'(i);
            w_data_in = wm[i];
            w_wr_en   = 1'b1;
            @(posedge clk); #1;
        end
        w_wr_en = 1'b0;
    endtask

    task automatic set_identity();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                wm[r*N+c] = (r == c) ? 16'sd1 : 16'sd0;
    endtask

    // Streams xv in; returns aligned just after the edge that took the last element.
    task automatic send_vec();
        for (int i = 0; i < N; i++) begin
            int  budget = 0;
            logic ok;
            s_valid_x   = 1'b1;
            s_data_in_x = xv[i];
            do begin
                @(negedge clk);
                ok = s_ready_x;
                @(posedge clk); #1;
                budget++;
            end while (!ok && budget < 500);
            if (!ok) check("send_timeout", 0, 1);
        end
        s_valid_x = 1'b0;
    endtask

    // Counts cycles from the last accept to the first m_valid_y (ready held low).
    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!m_valid_y && cyc < 200);
        @(posedge clk); #1;
    endtask

    // Collects M outputs under a ready pattern and compares them with ev.
    task automatic recv(input string name, input logic [31:0] rdy_pat);
        int   idx = 0;
        int   k = 0;
        int   budget = 0;
        logic stalled = 1'b0;
        logic sr_seen = 1'b0;
        logic signed [WIDTH-1:0] held = '0;
        while (idx < M && budget < 3000) begin
            m_ready_y = rdy_pat[k % 32];
            k++;
            @(negedge clk);
            budget++;
            if (s_ready_x) sr_seen = 1'b1;
            if (stalled) begin
                check({name, "_stall_valid"}, longint'(m_valid_y), 1);
                check({name, "_stall_data"}, m_data_out_y, held);
            end
            if (m_valid_y) begin
                if (m_ready_y) begin
                    check($sformatf("%s_y%0d", name, idx), m_data_out_y, ev[idx]);
                    idx++;
                    stalled = 1'b0;
                end else begin
                    held    = m_data_out_y;
                    stalled = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        m_ready_y = 1'b0;
        check({name, "_count"}, idx, M);
        check({name, "_sready_low"}, longint'(sr_seen), 0);
    endtask

    initial begin
        int lat;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", longint'(m_valid_y), 0);
        check("rst_ready", longint'(s_ready_x), 0);
        check("rst_data", m_data_out_y, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_ready_after", longint'(s_ready_x), 1);

        // Identity weights, latency
        set_identity();
        load_w();
        for (int i = 0; i < N; i++) xv[i] = WIDTH'(i + 1);
        for (int i = 0; i < M; i++) ev[i] = i + 1;
        send_vec();
        wait_valid(lat);
        check("latency", lat, N + 3);
        recv("ident", 32'hFFFF_FFFF);

        // Dense mixed-sign weights W[r][c] = r - c, x = 1..8
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                wm[r*N+c] = WIDTH'(r - c);
        load_w();
`ifdef FC_RELU_EN
        ev = '{0, 0, 0, 0, 0, 12, 48, 84};
`else
        ev = '{-168, -132, -96, -60, -24, 12, 48, 84};
`endif
        send_vec();
        recv("dense", 32'hFFFF_FFFF);

        // Positive saturation
        for (int i = 0; i < M*N; i++) wm[i] = 16'sd32767;
        load_w();
        for (int i = 0; i < N; i++) xv[i] = 16'sd32767;
        for (int i = 0; i < M; i++) ev[i] = 32767;
        send_vec();
        recv("satpos", 32'hFFFF_FFFF);

        // Negative saturation
        for (int i = 0; i < M*N; i++) wm[i] = -16'sd32768;
        load_w();
`ifdef FC_RELU_EN
        for (int i = 0; i < M; i++) ev[i] = 0;
`else
        for (int i = 0; i < M; i++) ev[i] = -32768;
`endif
        send_vec();
        recv("satneg", 32'hFFFF_FFFF);

        // ReLU rows: row0 all -1, row1 all +1
        for (int i = 0; i < M*N; i++) wm[i] = 16'sd0;
        for (int c = 0; c < N; c++) begin
            wm[c]     = -16'sd1;
            wm[N + c] = 16'sd1;
        end
        load_w();
        for (int i = 0; i < N; i++) xv[i] = 16'sd5;
        for (int i = 0; i < M; i++) ev[i] = 0;
`ifdef FC_RELU_EN
        ev[0] = 0;
`else
        ev[0] = -40;
`endif
        ev[1] = 40;
        send_vec();
        recv("relu", 32'hFFFF_FFFF);

        // Backpressure on identity weights
        set_identity();
        load_w();
        xv = '{16'sd3, -16'sd7, 16'sd100, -16'sd200, 16'sd32767, -16'sd32768, 16'sd0, 16'sd1};
        for (int i = 0; i < N; i++) ev[i] = longint'(xv[i]);
        send_vec();
        recv("bp", 32'b1001_0110_1100_1001_0011_1010_0101_1001);

        // Weight writes during COMPUTE are ignored
        for (int i = 0; i < N; i++) xv[i] = WIDTH'(i + 1);
        for (int i = 0; i < M; i++) ev[i] = i + 1;
        send_vec();
        w_addr = '0; w_data_in = 16'sd100; w_wr_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        w_wr_en = 1'b0;
        recv("wgate_busy", 32'hFFFF_FFFF);

        // The same write in LOAD_X takes effect on the next vector
        w_addr = '0; w_data_in = 16'sd100; w_wr_en = 1'b1;
        @(posedge clk); #1;
        w_wr_en = 1'b0;
        ev[0] = 100;
        send_vec();
        recv("wgate_idle", 32'hFFFF_FFFF);

        // Async reset mid-COMPUTE
        send_vec();
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rstc_valid", longint'(m_valid_y), 0);
        check("rstc_ready", longint'(s_ready_x), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstc_ready_pre", longint'(s_ready_x), 0);
        @(posedge clk); #1;
        check("rstc_ready_post", longint'(s_ready_x), 1);
        send_vec();
        recv("rstc_next", 32'hFFFF_FFFF);

        // Async reset while an output is presented and stalled
        send_vec();
        wait_valid(lat);
        check("rsto_valid_pre", longint'(m_valid_y), 1);
        #2;
        reset = 1'b1;
        #1;
        check("rsto_valid", longint'(m_valid_y), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("rsto_ready_post", longint'(s_ready_x), 1);
        send_vec();
        recv("rsto_next", 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
